// File: rtl/char_grid_writer_if.sv
// Character-stream and cell-write bus between a text source and char_grid_writer.
// The source drives codes and scroll_done; the writer drives the RAM write and cursor outputs.
interface char_grid_writer_if #(
  parameter int unsigned ROW_BIT_LEN = 4,
  parameter int unsigned COL_BIT_LEN = 6,
  parameter int unsigned CHAR_ID_LEN = 8
);
  logic [CHAR_ID_LEN-1:0] idi;
  logic                   we;
  logic                   scroll_done;
  logic                   ready;
  logic                   wr_en;
  logic [ROW_BIT_LEN-1:0] wr_r;
  logic [COL_BIT_LEN-1:0] wr_c;
  logic [CHAR_ID_LEN-1:0] ido;
  logic [ROW_BIT_LEN-1:0] r;
  logic [COL_BIT_LEN-1:0] c;
  logic                   s;
  logic                   clr;

  modport master (
    output idi, we, scroll_done,
    input  ready, wr_en, wr_r, wr_c, ido, r, c, s, clr
  );

  modport slave (
    input  idi, we, scroll_done,
    output ready, wr_en, wr_r, wr_c, ido, r, c, s, clr
  );
endinterface

// File: rtl/char_grid_writer.sv
// Text-console cursor engine: decodes character codes to glyph IDs and emits per-cell RAM
// writes, with a full-screen blank sweep on clear and a scroll handshake plus last-row fill.
module char_grid_writer #(
  parameter int unsigned ROW_NUMBER  = 7,
  parameter int unsigned COL_NUMBER  = 20,
  parameter int unsigned ROW_BIT_LEN = 4,
  parameter int unsigned COL_BIT_LEN = 6,
  parameter int unsigned CHAR_ID_LEN = 8,
  parameter int unsigned BLANK_ID    = 130
) (
  input logic               clk,
  input logic               reset,
  char_grid_writer_if.slave bus
);

  localparam logic [ROW_BIT_LEN-1:0] LastRow   = ROW_BIT_LEN'(ROW_NUMBER - 1);
  localparam logic [COL_BIT_LEN-1:0] LastCol   = COL_BIT_LEN'(COL_NUMBER - 1);
  localparam logic [ROW_BIT_LEN-1:0] RowOne    = ROW_BIT_LEN'(1);
  localparam logic [COL_BIT_LEN-1:0] ColOne    = COL_BIT_LEN'(1);
  localparam logic [CHAR_ID_LEN-1:0] BlankId   = CHAR_ID_LEN'(BLANK_ID);
  localparam logic [CHAR_ID_LEN-1:0] CodeClear = CHAR_ID_LEN'(8'hFF);
  localparam logic [CHAR_ID_LEN-1:0] CodeLf    = CHAR_ID_LEN'(8'h0A);
  localparam logic [CHAR_ID_LEN-1:0] CodeCr    = CHAR_ID_LEN'(8'h0D);
  localparam logic [CHAR_ID_LEN-1:0] CodeBs    = CHAR_ID_LEN'(8'h08);

  typedef enum logic [1:0] {StIdle, StClear, StScrollWait, StRowFill} state_e;

  state_e                 state_q, state_d;
  logic                   ready_q, ready_d;
  logic                   wr_en_q, wr_en_d;
  logic [ROW_BIT_LEN-1:0] wr_r_q, wr_r_d;
  logic [COL_BIT_LEN-1:0] wr_c_q, wr_c_d;
  logic [CHAR_ID_LEN-1:0] ido_q, ido_d;
  logic [ROW_BIT_LEN-1:0] r_q, r_d;
  logic [COL_BIT_LEN-1:0] c_q, c_d;
  logic                   s_q, s_d;
  logic                   clr_q, clr_d;

  function automatic logic [CHAR_ID_LEN-1:0] glyph_of(input logic [CHAR_ID_LEN-1:0] code);
    int unsigned v;
    v = 32'(code);
    if (v >= 48 && v <= 57)        glyph_of = CHAR_ID_LEN'(v - 48);
    else if (v >= 65 && v <= 90)   glyph_of = CHAR_ID_LEN'(v - 55);
    else if (v >= 97 && v <= 122)  glyph_of = CHAR_ID_LEN'(v - 61);
    else if (v >= 128 && v <= 195) glyph_of = CHAR_ID_LEN'(v - 66);
    else                           glyph_of = BlankId;
  endfunction

  // The write-address registers double as the sweep/fill counters while clearing or filling.
  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    wr_en_d = 1'b0;
    wr_r_d  = wr_r_q;
    wr_c_d  = wr_c_q;
    ido_d   = ido_q;
    r_d     = r_q;
    c_d     = c_q;
    s_d     = 1'b0;
    clr_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.we && ready_q) begin
          if (bus.idi == CodeClear) begin
            r_d     = '0;
            c_d     = '0;
            state_d = StClear;
            ready_d = 1'b0;
            clr_d   = 1'b1;
            wr_en_d = 1'b1;
            wr_r_d  = '0;
            wr_c_d  = '0;
            ido_d   = BlankId;
          end else if (bus.idi == CodeLf) begin
            c_d = '0;
            if (r_q == LastRow) begin
              state_d = StScrollWait;
              ready_d = 1'b0;
              s_d     = 1'b1;
            end else begin
              r_d = r_q + RowOne;
            end
          end else if (bus.idi == CodeCr) begin
            c_d = '0;
          end else if (bus.idi == CodeBs) begin
            if (c_q != '0) begin
              c_d     = c_q - ColOne;
              wr_en_d = 1'b1;
              wr_r_d  = r_q;
              wr_c_d  = c_q - ColOne;
              ido_d   = BlankId;
            end else if (r_q != '0) begin
              r_d     = r_q - RowOne;
              c_d     = LastCol;
              wr_en_d = 1'b1;
              wr_r_d  = r_q - RowOne;
              wr_c_d  = LastCol;
              ido_d   = BlankId;
            end
          end else begin
            wr_en_d = 1'b1;
            wr_r_d  = r_q;
            wr_c_d  = c_q;
            ido_d   = glyph_of(bus.idi);
            if (c_q == LastCol) begin
              c_d = '0;
              if (r_q == LastRow) begin
                state_d = StScrollWait;
                ready_d = 1'b0;
                s_d     = 1'b1;
              end else begin
                r_d = r_q + RowOne;
              end
            end else begin
              c_d = c_q + ColOne;
            end
          end
        end
      end
      StClear: begin
        if (wr_r_q == LastRow && wr_c_q == LastCol) begin
          state_d = StIdle;
          ready_d = 1'b1;
        end else begin
          wr_en_d = 1'b1;
          if (wr_c_q == LastCol) begin
            wr_c_d = '0;
            wr_r_d = wr_r_q + RowOne;
          end else begin
            wr_c_d = wr_c_q + ColOne;
          end
        end
      end
      StScrollWait: begin
        if (bus.scroll_done) begin
          state_d = StRowFill;
          wr_en_d = 1'b1;
          wr_r_d  = LastRow;
          wr_c_d  = '0;
          ido_d   = BlankId;
        end
      end
      StRowFill: begin
        if (wr_c_q == LastCol) begin
          state_d = StIdle;
          ready_d = 1'b1;
        end else begin
          wr_en_d = 1'b1;
          wr_c_d  = wr_c_q + ColOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      ready_q <= 1'b1;
      wr_en_q <= 1'b0;
      wr_r_q  <= '0;
      wr_c_q  <= '0;
      ido_q   <= '0;
      r_q     <= '0;
      c_q     <= '0;
      s_q     <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      wr_en_q <= wr_en_d;
      wr_r_q  <= wr_r_d;
      wr_c_q  <= wr_c_d;
      ido_q   <= ido_d;
      r_q     <= r_d;
      c_q     <= c_d;
      s_q     <= s_d;
      clr_q   <= clr_d;
    end
  end

  assign bus.ready = ready_q;
  assign bus.wr_en = wr_en_q;
  assign bus.wr_r  = wr_r_q;
  assign bus.wr_c  = wr_c_q;
  assign bus.ido   = ido_q;
  assign bus.r     = r_q;
  assign bus.c     = c_q;
  assign bus.s     = s_q;
  assign bus.clr   = clr_q;

endmodule

// File: tb/tb_char_grid_writer.sv
// Directed bench for char_grid_writer: a vector table for single-code behaviour plus
// hand-written clear, scroll and reset sequences on the default 7x20 grid.
module tb_char_grid_writer;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  char_grid_writer_if #(.ROW_BIT_LEN(4), .COL_BIT_LEN(6), .CHAR_ID_LEN(8)) bus ();

  char_grid_writer dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    bit         wr;
    int         wr_r;
    int         wr_c;
    int         ido;
    int         r;
    int         c;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, int'(bus.ready), 1);
    chk({tag, "_wr_en"}, int'(bus.wr_en), 0);
    chk({tag, "_wr_r"}, int'(bus.wr_r), 0);
    chk({tag, "_wr_c"}, int'(bus.wr_c), 0);
    chk({tag, "_ido"}, int'(bus.ido), 0);
    chk({tag, "_r"}, int'(bus.r), 0);
    chk({tag, "_c"}, int'(bus.c), 0);
    chk({tag, "_s"}, int'(bus.s), 0);
    chk({tag, "_clr"}, int'(bus.clr), 0);
  endtask

  // Called with the first fill write visible; walks the 20 blank writes on row 6.
  task automatic chk_row_fill(input string tag);
    int nw, bad, guard;
    nw = 0;
    bad = 0;
    guard = 0;
    while (!bus.ready && guard < 100) begin
      if (bus.wr_en) begin
        if (int'(bus.wr_r) != 6 || int'(bus.wr_c) != nw || int'(bus.ido) != 130) bad++;
        nw++;
      end
      guard++;
      step();
    end
    chk({tag, "_fill_ready"}, int'(bus.ready), 1);
    chk({tag, "_fill_writes"}, nw, 20);
    chk({tag, "_fill_addr_bad"}, bad, 0);
    chk({tag, "_fill_wr_en_after"}, int'(bus.wr_en), 0);
    chk({tag, "_fill_r"}, int'(bus.r), 6);
    chk({tag, "_fill_c"}, int'(bus.c), 0);
  endtask

  initial begin
    int er, ec, nw, nlow, nclr, bad, guard;
    n_checks = 0;
    n_fail = 0;
    reset = 1'b1;
    bus.idi = '0;
    bus.we = 1'b0;
    bus.scroll_done = 1'b0;

    //                code   wr  wr_r wr_c ido  r  c
    vecs[0]  = '{8'd65,  1'b1, 0,  0,  10,  0, 1};
    vecs[1]  = '{8'd122, 1'b1, 0,  1,  61,  0, 2};
    vecs[2]  = '{8'd57,  1'b1, 0,  2,  9,   0, 3};
    vecs[3]  = '{8'h7F,  1'b1, 0,  3,  130, 0, 4};
    vecs[4]  = '{8'd32,  1'b1, 0,  4,  130, 0, 5};
    vecs[5]  = '{8'd128, 1'b1, 0,  5,  62,  0, 6};
    vecs[6]  = '{8'd195, 1'b1, 0,  6,  129, 0, 7};
    vecs[7]  = '{8'h0D,  1'b0, 0,  0,  0,   0, 0};
    vecs[8]  = '{8'h08,  1'b0, 0,  0,  0,   0, 0};
    vecs[9]  = '{8'h0A,  1'b0, 0,  0,  0,   1, 0};
    vecs[10] = '{8'd97,  1'b1, 1,  0,  36,  1, 1};
    vecs[11] = '{8'h0A,  1'b0, 0,  0,  0,   2, 0};
    vecs[12] = '{8'h08,  1'b1, 1,  19, 130, 1, 19};
    vecs[13] = '{8'd66,  1'b1, 1,  19, 11,  2, 0};
    vecs[14] = '{8'd48,  1'b1, 2,  0,  0,   2, 1};
    vecs[15] = '{8'h08,  1'b1, 2,  0,  130, 2, 0};
    vecs[16] = '{8'd47,  1'b1, 2,  0,  130, 2, 1};
    vecs[17] = '{8'd91,  1'b1, 2,  1,  130, 2, 2};
    vecs[18] = '{8'd196, 1'b1, 2,  2,  130, 2, 3};
    vecs[19] = '{8'h0D,  1'b0, 0,  0,  0,   2, 0};

    step();
    step();
    chk_reset_outputs("por");
    reset = 1'b0;
    step();

    // Back-to-back codes; ready must stay high throughout.
    for (int i = 0; i < 20; i++) begin
      bus.we = 1'b1;
      bus.idi = vecs[i].code;
      step();
      chk($sformatf("v%0d_wr_en", i), int'(bus.wr_en), int'(vecs[i].wr));
      if (vecs[i].wr) begin
        chk($sformatf("v%0d_wr_r", i), int'(bus.wr_r), vecs[i].wr_r);
        chk($sformatf("v%0d_wr_c", i), int'(bus.wr_c), vecs[i].wr_c);
        chk($sformatf("v%0d_ido", i), int'(bus.ido), vecs[i].ido);
      end
      chk($sformatf("v%0d_r", i), int'(bus.r), vecs[i].r);
      chk($sformatf("v%0d_c", i), int'(bus.c), vecs[i].c);
      chk($sformatf("v%0d_ready", i), int'(bus.ready), 1);
    end
    bus.we = 1'b0;
    step();

    // Clear sweep from cursor (2,0).
    bus.we = 1'b1;
    bus.idi = 8'hFF;
    step();
    bus.we = 1'b0;
    chk("clr_cursor_r", int'(bus.r), 0);
    chk("clr_cursor_c", int'(bus.c), 0);
    er = 0; ec = 0; nw = 0; nlow = 0; nclr = 0; bad = 0; guard = 0;
    while (!bus.ready && guard < 400) begin
      nlow++;
      if (bus.clr) nclr++;
      if (bus.clr && nlow != 1) bad++;
      if (bus.wr_en) begin
        if (int'(bus.wr_r) != er || int'(bus.wr_c) != ec || int'(bus.ido) != 130) bad++;
        nw++;
        if (ec == 19) begin
          ec = 0;
          er++;
        end else begin
          ec++;
        end
      end
      guard++;
      step();
    end
    chk("clr_ready_after", int'(bus.ready), 1);
    chk("clr_writes", nw, 140);
    chk("clr_ready_low_cycles", nlow, 140);
    chk("clr_pulses", nclr, 1);
    chk("clr_addr_bad", bad, 0);
    chk("clr_wr_en_after", int'(bus.wr_en), 0);
    chk("clr_end_r", int'(bus.r), 0);
    chk("clr_end_c", int'(bus.c), 0);

    // 140 printables fill the screen; the last write coincides with s.
    bus.we = 1'b1;
    bus.idi = 8'd65;
    for (int i = 0; i < 140; i++) step();
    chk("full_last_wr_en", int'(bus.wr_en), 1);
    chk("full_last_wr_r", int'(bus.wr_r), 6);
    chk("full_last_wr_c", int'(bus.wr_c), 19);
    chk("full_last_ido", int'(bus.ido), 10);
    chk("full_s", int'(bus.s), 1);
    chk("full_ready", int'(bus.ready), 0);
    chk("full_r", int'(bus.r), 6);
    chk("full_c", int'(bus.c), 0);
    // we held high while ready=0 must be ignored.
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("wait%0d_s", i), int'(bus.s), 0);
      chk($sformatf("wait%0d_wr_en", i), int'(bus.wr_en), 0);
      chk($sformatf("wait%0d_ready", i), int'(bus.ready), 0);
    end
    chk("wait_cursor_c", int'(bus.c), 0);
    bus.we = 1'b0;
    bus.scroll_done = 1'b1;
    step();
    bus.scroll_done = 1'b0;
    chk_row_fill("scroll");

    // scroll_done in IDLE is ignored; newline at row 6 scrolls with no write.
    bus.scroll_done = 1'b1;
    step();
    chk("idle_sd_ready", int'(bus.ready), 1);
    chk("idle_sd_wr_en", int'(bus.wr_en), 0);
    bus.scroll_done = 1'b0;
    bus.we = 1'b1;
    bus.idi = 8'h0A;
    step();
    chk("lf_s", int'(bus.s), 1);
    chk("lf_wr_en", int'(bus.wr_en), 0);
    chk("lf_ready", int'(bus.ready), 0);
    bus.we = 1'b0;
    bus.scroll_done = 1'b1;  // seen during the s cycle
    step();
    bus.scroll_done = 1'b0;
    chk("lf_fill_start_s", int'(bus.s), 0);
    chk_row_fill("lf");

    // Reset in the middle of a clear sweep.
    bus.we = 1'b1;
    bus.idi = 8'hFF;
    step();
    bus.we = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("midclr_ready_low", int'(bus.ready), 0);
    reset = 1'b1;
    #1;
    chk_reset_outputs("rst_clear");
    step();
    reset = 1'b0;
    step();
    chk("post_rst_clear_wr_en", int'(bus.wr_en), 0);
    chk("post_rst_clear_ready", int'(bus.ready), 1);

    // Reset in SCROLL_WAIT: seven newlines from (0,0).
    bus.we = 1'b1;
    bus.idi = 8'h0A;
    for (int i = 0; i < 7; i++) step();
    bus.we = 1'b0;
    chk("nl7_s", int'(bus.s), 1);
    chk("nl7_ready", int'(bus.ready), 0);
    step();
    reset = 1'b1;
    #1;
    chk_reset_outputs("rst_scroll");
    step();
    reset = 1'b0;
    bus.we = 1'b1;
    bus.idi = 8'd90;
    step();
    bus.we = 1'b0;
    chk("post_rst_wr_en", int'(bus.wr_en), 1);
    chk("post_rst_wr_r", int'(bus.wr_r), 0);
    chk("post_rst_wr_c", int'(bus.wr_c), 0);
    chk("post_rst_ido", int'(bus.ido), 35);
    chk("post_rst_c", int'(bus.c), 1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
